// File: rtl/instruction_encoder.sv
// Instruction encoder: turns an operation select plus register/immediate
// fields into a 32-bit instruction word. It rejects illegal requests with an
// error pulse and a saturating count, tags each accepted word with a running
// byte address, and buffers words in a 2-entry FIFO behind a valid/ready
// output handshake.
module instruction_encoder (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op_sel,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_count
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_ORR  = 4'd3,
    OP_EOR  = 4'd4,  OP_ADDI = 4'd5,  OP_SUBI = 4'd6,  OP_ANDI = 4'd7,
    OP_ORRI = 4'd8,  OP_EORI = 4'd9,  OP_LDUR = 4'd10, OP_STUR = 4'd11,
    OP_CBZ  = 4'd12, OP_B    = 4'd13, OP_MOVZ = 4'd14, OP_ILL  = 4'd15
  } op_e;

  op_e         op;
  logic [31:0] word;
  logic        legal;

  logic        accept;
  logic        push;
  logic        pop;
  logic        reject;

  logic        ready_en;   // low in reset, high from the first edge after it
  logic [1:0]  count;      // occupancy, 0..2
  logic        rd_ptr;
  logic        wr_ptr;
  logic [31:0] pc;

  logic [31:0] mem_instr [2];
  logic [31:0] mem_addr  [2];

  assign op = op_e'(op_sel);

  // Field packing and immediate range checks for every operation.
  // NOTE: every output of a combinational block gets a default first;
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (op)
      OP_ADD:  begin word = {11'b10001011000, rm, 6'b0, rn, rd}; legal = 1'b1; end
      OP_SUB:  begin word = {11'b11001011000, rm, 6'b0, rn, rd}; legal = 1'b1; end
      OP_AND:  begin word = {11'b10001010000, rm, 6'b0, rn, rd}; legal = 1'b1; end
      OP_ORR:  begin word = {11'b10101010000, rm, 6'b0, rn, rd}; legal = 1'b1; end
      OP_EOR:  begin word = {11'b11101010000, rm, 6'b0, rn, rd}; legal = 1'b1; end
      OP_ADDI: begin word = {10'b1001000100, imm[11:0], rn, rd}; legal = (imm[31:12] == 20'd0); end
      OP_SUBI: begin word = {10'b1101000100, imm[11:0], rn, rd}; legal = (imm[31:12] == 20'd0); end
      OP_ANDI: begin word = {10'b1001001000, imm[11:0], rn, rd}; legal = (imm[31:12] == 20'd0); end
      OP_ORRI: begin word = {10'b1011001000, imm[11:0], rn, rd}; legal = (imm[31:12] == 20'd0); end
      OP_EORI: begin word = {10'b1101001000, imm[11:0], rn, rd}; legal = (imm[31:12] == 20'd0); end
      OP_LDUR: begin
        word  = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
        legal = (imm[31:8] == {24{imm[8]}});
      end
      OP_STUR: begin
        word  = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
        legal = (imm[31:8] == {24{imm[8]}});
      end
      OP_CBZ: begin
        word  = {8'b10110100, imm[18:0], rd};
        legal = (imm[31:18] == {14{imm[18]}});
      end
      OP_B: begin
        word  = {6'b000101, imm[25:0]};
        legal = (imm[31:25] == {7{imm[25]}});
      end
      OP_MOVZ: begin
        word  = {9'b110100101, 2'b00, imm[15:0], rd};
        legal = (imm[31:16] == 16'd0);
      end
      default: begin word = '0; legal = 1'b0; end
    endcase
  end

  // Handshake decode; in_ready looks at occupancy before any same-cycle pop.
  assign in_ready  = ready_en && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign reject    = accept && !legal;
  assign pop       = out_valid && out_ready;

  // The head is masked while the FIFO is empty, so the storage needs no reset.
  assign out_instr = out_valid ? mem_instr[rd_ptr] : 32'd0;
  assign out_addr  = out_valid ? mem_addr[rd_ptr]  : 32'd0;

  // FIFO pointers, occupancy, pc and the ready enable.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_en <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      pc       <= 32'd0;
    end else begin
      ready_en <= 1'b1;
      if (clear) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        pc     <= 32'd0;
      end else begin
        if (push) begin
          wr_ptr <= ~wr_ptr;
          pc     <= pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        count <= count + 2'(push) - 2'(pop);
      end
    end
  end

  // FIFO storage write.
  // NOTE: the storage array is deliberately left out of reset; the occupancy
  // count is what says whether an entry is meaningful.
  always_ff @(posedge clock) begin
    if (push && !clear) begin
      mem_instr[wr_ptr] <= word;
      mem_addr[wr_ptr]  <= pc;
    end
  end

  // Error pulse and the saturating reject counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err       <= 1'b0;
      err_count <= 8'd0;
    end else if (clear) begin
      err       <= 1'b0;
      err_count <= 8'd0;
    end else begin
      err <= reject;
      if (reject && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder. A scoreboard queue holds the
// expected words with their addresses; a negedge monitor pops and compares
// on every output transfer.
module tb_instruction_encoder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op_sel;
  logic [4:0]  rd, rn, rm;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic [7:0]  err_count;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_pc = 32'd0;
  logic [7:0]  exp_errs = 8'd0;
  int          checks = 0;
  int          errors = 0;

  instruction_encoder dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sel    (op_sel),
    .rd        (rd),
    .rn        (rn),
    .rm        (rm),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Scoreboard compare on every output transfer.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", {31'b0, out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("instr", out_instr, e.instr);
        check("addr", out_addr, e.addr);
      end
    end
  end

  // Drive one request and wait (bounded) for acceptance. Legal words go to the
  // scoreboard; rejected ones get their err pulse and count checked.
  task automatic send(input logic [3:0] op, input logic [4:0] d, input logic [4:0] n,
                      input logic [4:0] m, input logic [31:0] im,
                      input logic legal, input logic [31:0] exp_instr);
    bit accepted = 0;
    @(posedge clock); #1;
    in_valid = 1'b1; op_sel = op; rd = d; rn = n; rm = m; imm = im;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clock);
      if (in_ready) accepted = 1;
    end
    if (!accepted) begin
      check("accept_timeout", {31'b0, in_ready}, 32'd1);
    end else if (legal) begin
      sb.push_back('{exp_instr, exp_pc});
      exp_pc += 32'd4;
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    op_sel = 4'($urandom); rd = 5'($urandom); rn = 5'($urandom); rm = 5'($urandom);
    imm = $urandom;
    if (accepted && !legal) begin
      if (exp_errs != 8'hFF) exp_errs += 8'd1;
      @(negedge clock);
      check("err_pulse", {31'b0, err}, 32'd1);
      check("err_count", {24'b0, err_count}, {24'b0, exp_errs});
      @(negedge clock);
      check("err_low", {31'b0, err}, 32'd0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clock);
    check("drain", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_sel = '0; rd = '0; rn = '0; rm = '0; imm = '0;
    repeat (3) @(negedge clock);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_err_count", {24'b0, err_count}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("ready_before_edge", {31'b0, in_ready}, 32'd0);
    @(negedge clock);
    check("ready_after_edge", {31'b0, in_ready}, 32'd1);

    // Single ADD, visible one cycle after acceptance, with unused imm ignored.
    send(4'd0, 5'd1, 5'd2, 5'd3, 32'hDEADBEEF, 1'b1, 32'h8B030041);
    @(negedge clock);
    drain();

    // Clear with a word pending: FIFO emptied, pc back to 0.
    out_ready = 1'b0;
    send(4'd3, 5'd4, 5'd5, 5'd6, 32'd0, 1'b1, 32'hAA0600A4);
    @(posedge clock); #1; clear = 1'b1;
    @(posedge clock); #1; clear = 1'b0;
    @(negedge clock);
    check("clear_out_valid", {31'b0, out_valid}, 32'd0);
    sb.delete(); exp_pc = 32'd0; exp_errs = 8'd0;
    out_ready = 1'b1;

    // Mixed formats at addresses 0, 4, 8, 0xC.
    send(4'd5,  5'd1, 5'd2, 5'd31, 32'd5,         1'b1, 32'h91001441);
    send(4'd10, 5'd1, 5'd2, 5'd31, 32'd8,         1'b1, 32'hF8408041);
    send(4'd12, 5'd9, 5'd7, 5'd7,  32'd2,         1'b1, 32'hB4000049);
    send(4'd13, 5'd3, 5'd4, 5'd5,  32'hFFFFFFFF,  1'b1, 32'h17FFFFFF);
    drain();

    // Rejections: illegal op, then ADDI just out of range.
    send(4'd15, 5'd1, 5'd2, 5'd3, 32'd0,    1'b0, 32'd0);
    send(4'd5,  5'd1, 5'd2, 5'd3, 32'd4096, 1'b0, 32'd0);
    check("err_count_two", {24'b0, err_count}, 32'd2);

    // Range boundaries; the first legal word shows pc did not move.
    send(4'd5,  5'd0, 5'd0, 5'd0, 32'd4095,      1'b1, 32'h913FFC00);
    send(4'd10, 5'd0, 5'd0, 5'd0, -32'sd256,     1'b1, 32'hF8500000);
    send(4'd11, 5'd0, 5'd0, 5'd0, 32'd256,       1'b0, 32'd0);
    send(4'd14, 5'd3, 5'd9, 5'd9, 32'd65535,     1'b1, 32'hD29FFFE3);
    send(4'd14, 5'd3, 5'd9, 5'd9, 32'd65536,     1'b0, 32'd0);
    send(4'd12, 5'd0, 5'd0, 5'd0, -32'sd262144,  1'b1, 32'hB4800000);
    send(4'd13, 5'd0, 5'd0, 5'd0, 32'h02000000,  1'b1 & 1'b0, 32'd0);
    drain();

    // Backpressure: two pushes fill the FIFO, head held, third waits for a pop.
    out_ready = 1'b0;
    send(4'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 32'h8B030041);
    send(4'd1, 5'd4, 5'd5, 5'd6, 32'd0, 1'b1, 32'hCB0600A4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("full_in_ready", {31'b0, in_ready}, 32'd0);
      check("held_instr", out_instr, 32'h8B030041);
    end
    fork
      send(4'd4, 5'd7, 5'd8, 5'd9, 32'd0, 1'b1, 32'hEA090107);
      begin
        repeat (2) @(negedge clock);
        check("third_waits", {31'b0, in_ready}, 32'd0);
        @(posedge clock); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two entries queued.
    out_ready = 1'b0;
    send(4'd2, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1, 32'd0);
    send(4'd2, 5'd2, 5'd2, 5'd2, 32'd0, 1'b1, 32'd0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("mid_rst_instr", out_instr, 32'd0);
    check("mid_rst_addr", out_addr, 32'd0);
    check("mid_rst_err_count", {24'b0, err_count}, 32'd0);
    sb.delete(); exp_pc = 32'd0; exp_errs = 8'd0;
    @(posedge clock); #1;
    reset_n = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    send(4'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 32'h8B030041);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
